// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl -- data-memory controller behind the memory-access stage.
//
// Turns the stage's memreq_* request into a single word-wide valid/ready bus
// transaction with byte strobes. Returns LSB-aligned, zero-extended load data
// (sign extension is left to the stage). The pipeline is stalled while the bus
// transaction is outstanding.
//
// Optional build macro: DMEM_TIMEOUT_EN
//   When defined, an 8-bit wait counter limits the BUS state to TIMEOUT_CYCLES
//   cycles. On expiry the access completes with 32'hDEADBEEF and the extra
//   output bus_timeout is high for that DONE cycle. Without the macro the
//   controller waits on bus_ready indefinitely and bus_timeout does not exist.
//
// Ports:
//   clk, reset           clock (rising edge), synchronous active-high reset
//   flush                discard any pending or returning access
//   pipe_stall           stall from other hazard sources; holds DONE
//   memreq_addr          byte address
//   memreq_write_enable  store request
//   memreq_write_data    store data, LSB-aligned
//   memreq_data_width    funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   memreq_ready         load request
//   memresp_data         aligned, zero-extended load data
//   memresp_valid        response valid (DONE only)
//   mem_stall            pipeline stall request
//   misaligned           combinational misaligned-access flag
//   bus_valid/bus_ready  bus handshake
//   bus_addr             word address ([1:0] = 00)
//   bus_we, bus_wstrb    write enable and byte strobes
//   bus_wdata            lane-replicated store data
//   bus_rdata            bus read word
//   bus_timeout          (DMEM_TIMEOUT_EN only) timeout flag in DONE
// -----------------------------------------------------------------------------
module dmem_ctrl #(
   parameter int RESET_PC_UNUSED = 0,
   parameter int TIMEOUT_CYCLES  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        pipe_stall,
   input  logic [31:0] memreq_addr,
   input  logic        memreq_write_enable,
   input  logic [31:0] memreq_write_data,
   input  logic [2:0]  memreq_data_width,
   input  logic        memreq_ready,
   output logic [31:0] memresp_data,
   output logic        memresp_valid,
   output logic        mem_stall,
   output logic        misaligned,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic [31:0] bus_addr,
   output logic        bus_we,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata
`ifdef DMEM_TIMEOUT_EN
   ,
   output logic        bus_timeout
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q,         state_d;
   logic        drop_q,          drop_d;
   logic        bus_valid_q,     bus_valid_d;
   logic        bus_we_q,        bus_we_d;
   logic [3:0]  bus_wstrb_q,     bus_wstrb_d;
   logic [31:0] bus_addr_q,      bus_addr_d;
   logic [31:0] bus_wdata_q,     bus_wdata_d;
   logic [1:0]  size_q,          size_d;
   logic [1:0]  off_q,           off_d;
   logic [31:0] memresp_data_q,  memresp_data_d;
   logic        memresp_valid_q, memresp_valid_d;
`ifdef DMEM_TIMEOUT_EN
   logic [7:0]  wait_cnt_q,      wait_cnt_d;
   logic        bus_timeout_q,   bus_timeout_d;
   logic        timed_out;
`endif

   logic        req_active;
   logic [1:0]  size_in;
   logic        misaligned_c;
   logic        issue;
   logic        discard;
   logic        unused_sig;

   // Access size from funct3[1:0]: 00 byte, 01 half, 1x word. Bit 2 only
   // selects zero- vs sign-extension, which is handled in the stage, so
   // unused width codes (011, 11x) fall into the word case.
   function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   lane_strb = 4'b0001 << off;
         2'b01:   lane_strb = 4'b0011 << {off[1], 1'b0};
         default: lane_strb = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
      case (size)
         2'b00:   lane_wdata = {4{d[7:0]}};
         2'b01:   lane_wdata = {2{d[15:0]}};
         default: lane_wdata = d;
      endcase
   endfunction

   function automatic logic [31:0] load_align(input logic [1:0] size, input logic [1:0] off,
                                              input logic [31:0] rdata);
      logic [31:0] shifted;
      shifted = rdata >> {off, 3'b000};
      case (size)
         2'b00:   load_align = {24'h0, shifted[7:0]};
         2'b01:   load_align = {16'h0, shifted[15:0]};
         default: load_align = shifted;
      endcase
   endfunction

   assign req_active   = memreq_ready | memreq_write_enable;
   assign size_in      = memreq_data_width[1:0];
   assign misaligned_c = req_active &
                         (((size_in == 2'b01) & memreq_addr[0]) |
                          (size_in[1] & (memreq_addr[1:0] != 2'b00)));
   assign issue        = (state_q == ST_IDLE) & req_active & ~misaligned_c & ~flush;
   // A flush arriving on the completion edge itself also discards the result.
   assign discard      = drop_q | flush;

`ifdef DMEM_TIMEOUT_EN
   assign timed_out = (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`endif

   always_comb begin
      state_d         = state_q;
      drop_d          = drop_q;
      bus_valid_d     = bus_valid_q;
      bus_we_d        = bus_we_q;
      bus_wstrb_d     = bus_wstrb_q;
      bus_addr_d      = bus_addr_q;
      bus_wdata_d     = bus_wdata_q;
      size_d          = size_q;
      off_d           = off_q;
      memresp_data_d  = memresp_data_q;
      memresp_valid_d = memresp_valid_q;
`ifdef DMEM_TIMEOUT_EN
      wait_cnt_d      = wait_cnt_q;
      bus_timeout_d   = bus_timeout_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (issue) begin
               state_d     = ST_BUS;
               drop_d      = 1'b0;
               bus_valid_d = 1'b1;
               // A request with both strobes set is treated as a store.
               bus_we_d    = memreq_write_enable;
               bus_wstrb_d = memreq_write_enable ? lane_strb(size_in, memreq_addr[1:0]) : 4'b0000;
               bus_addr_d  = {memreq_addr[31:2], 2'b00};
               bus_wdata_d = lane_wdata(size_in, memreq_write_data);
               size_d      = size_in;
               off_d       = memreq_addr[1:0];
`ifdef DMEM_TIMEOUT_EN
               wait_cnt_d  = 8'd0;
`endif
            end
         end

         ST_BUS: begin
            if (flush) drop_d = 1'b1;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt_d = wait_cnt_q + 8'd1;
`endif
            if (bus_ready) begin
               bus_valid_d = 1'b0;
               if (discard) begin
                  state_d = ST_IDLE;
                  drop_d  = 1'b0;
               end else begin
                  state_d         = ST_DONE;
                  memresp_valid_d = 1'b1;
                  memresp_data_d  = bus_we_q ? 32'h0 : load_align(size_q, off_q, bus_rdata);
               end
`ifdef DMEM_TIMEOUT_EN
            end else if (timed_out) begin
               bus_valid_d = 1'b0;
               if (discard) begin
                  state_d = ST_IDLE;
                  drop_d  = 1'b0;
               end else begin
                  state_d         = ST_DONE;
                  memresp_valid_d = 1'b1;
                  memresp_data_d  = 32'hDEADBEEF;
                  bus_timeout_d   = 1'b1;
               end
`endif
            end
         end

         ST_DONE: begin
            if (flush | ~pipe_stall) begin
               state_d         = ST_IDLE;
               memresp_valid_d = 1'b0;
`ifdef DMEM_TIMEOUT_EN
               bus_timeout_d   = 1'b0;
`endif
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         drop_q          <= 1'b0;
         bus_valid_q     <= 1'b0;
         bus_we_q        <= 1'b0;
         bus_wstrb_q     <= 4'b0000;
         bus_addr_q      <= 32'h0;
         bus_wdata_q     <= 32'h0;
         size_q          <= 2'b00;
         off_q           <= 2'b00;
         memresp_data_q  <= 32'h0;
         memresp_valid_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
         wait_cnt_q      <= 8'd0;
         bus_timeout_q   <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         drop_q          <= drop_d;
         bus_valid_q     <= bus_valid_d;
         bus_we_q        <= bus_we_d;
         bus_wstrb_q     <= bus_wstrb_d;
         bus_addr_q      <= bus_addr_d;
         bus_wdata_q     <= bus_wdata_d;
         size_q          <= size_d;
         off_q           <= off_d;
         memresp_data_q  <= memresp_data_d;
         memresp_valid_q <= memresp_valid_d;
`ifdef DMEM_TIMEOUT_EN
         wait_cnt_q      <= wait_cnt_d;
         bus_timeout_q   <= bus_timeout_d;
`endif
      end
   end

   // Stall covers the issuing cycle (combinational) and every BUS cycle,
   // including a BUS cycle whose result is being dropped.
   assign mem_stall     = issue | (state_q == ST_BUS);
   assign misaligned    = misaligned_c;
   assign memresp_data  = memresp_data_q;
   assign memresp_valid = memresp_valid_q;
   assign bus_valid     = bus_valid_q;
   assign bus_addr      = bus_addr_q;
   assign bus_we        = bus_we_q;
   assign bus_wstrb     = bus_wstrb_q;
   assign bus_wdata     = bus_wdata_q;
`ifdef DMEM_TIMEOUT_EN
   assign bus_timeout   = bus_timeout_q;
`endif

   assign unused_sig = ^{memreq_data_width[2], 32'(RESET_PC_UNUSED), 32'(TIMEOUT_CYCLES)};

endmodule
